// File: rtl/z_core_pkg.sv
// Shared Z-Core constants: control-unit opcodes, funct3 size/sign encodings,
// LSU state encoding and the funct3 legality helper.
package z_core_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_B   = 3'b000;
  localparam logic [2:0] F3_H   = 3'b001;
  localparam logic [2:0] F3_W   = 3'b010;
  localparam logic [2:0] F3_D   = 3'b011;
  localparam logic [2:0] F3_BU  = 3'b100;
  localparam logic [2:0] F3_HU  = 3'b101;
  localparam logic [2:0] F3_WU  = 3'b110;
  localparam logic [2:0] F3_INV = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_ISSUE2 = 3'd3,
    ST_WAIT2  = 3'd4,
    ST_RESP   = 3'd5
  } lsu_state_e;

  function automatic logic lsu_f3_illegal(input logic [2:0] f3, input logic wen,
                                          input logic is_64);
    logic ill;
    ill = 1'b0;
    if (f3 == F3_INV) begin
      ill = 1'b1;
    end else if (wen && f3[2]) begin
      ill = 1'b1;
    end else if (!is_64 && (f3 == F3_D || f3 == F3_WU)) begin
      ill = 1'b1;
    end else begin
      ill = 1'b0;
    end
    return ill;
  endfunction

endpackage

// File: rtl/z_core_lsu_align.sv
// Combinational lane logic: store strobe/data shifter over a two-beat window
// and load data extractor with sign/zero extension.
module z_core_lsu_align #(
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int OFF_W      = $clog2(STRB_WIDTH)
) (
  input  logic [OFF_W-1:0]        off,
  input  logic [1:0]              size_log2,
  input  logic                    zero_ext,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH-1:0]   beat0,
  input  logic [DATA_WIDTH-1:0]   beat1,
  output logic [2*STRB_WIDTH-1:0] wstrb,
  output logic [2*DATA_WIDTH-1:0] wdata_sh,
  output logic [DATA_WIDTH-1:0]   rdata
);

  logic [3:0]              nbytes_s;
  logic [2*STRB_WIDTH-1:0] mask_s;
  logic [DATA_WIDTH-1:0]   rd_sh_s;
  logic                    sign_s;

  // Lane shifting for both directions; upper halves belong to the second beat.
  always_comb begin
    nbytes_s = 4'd1 << size_log2;
    mask_s   = '0;
    for (int i = 0; i < 2 * STRB_WIDTH; i++) begin
      mask_s[i] = (i < int'(nbytes_s));
    end
    wstrb    = mask_s << off;
    wdata_sh = {{DATA_WIDTH{1'b0}}, wdata} << {off, 3'b000};
    rd_sh_s  = DATA_WIDTH'({beat1, beat0} >> {off, 3'b000});
    case (size_log2)
      2'd0:    sign_s = rd_sh_s[7];
      2'd1:    sign_s = rd_sh_s[15];
      2'd2:    sign_s = rd_sh_s[31];
      default: sign_s = rd_sh_s[DATA_WIDTH-1];
    endcase
    sign_s = sign_s & ~zero_ext;
    rdata  = '0;
    for (int i = 0; i < STRB_WIDTH; i++) begin
      rdata[8*i +: 8] = (i < int'(nbytes_s)) ? rd_sh_s[8*i +: 8] : {8{sign_s}};
    end
  end

endmodule

// File: rtl/z_core_lsu.sv
// Z-Core load/store unit. Define Z_CORE_LSU_MISALIGN_SPLIT_EN to complete
// misaligned accesses in hardware (two beats when crossing a beat boundary).
module z_core_lsu
  import z_core_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wen,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic                  resp_misaligned,
  output logic                  mem_req,
  output logic                  mem_wen,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [STRB_WIDTH-1:0] mem_wstrb,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ready,
  input  logic                  mem_busy
);

  localparam int OFF_W = $clog2(STRB_WIDTH);
  localparam logic IS_64 = (DATA_WIDTH == 64);
  localparam logic [ADDR_WIDTH-1:0] BEAT_BYTES = ADDR_WIDTH'(STRB_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] BEAT_MASK  = ~(BEAT_BYTES - ADDR_WIDTH'(1));
`ifdef Z_CORE_LSU_MISALIGN_SPLIT_EN
  localparam logic SPLIT_EN = 1'b1;
`else
  localparam logic SPLIT_EN = 1'b0;
`endif

  lsu_state_e              state_q, state_d;
  logic                    wen_q, wen_d;
  logic [2:0]              f3_q, f3_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   beat0_q, beat0_d;
  logic [DATA_WIDTH-1:0]   beat1_s;
  logic                    resp_valid_q, resp_valid_d;
  logic [DATA_WIDTH-1:0]   resp_rdata_q, resp_rdata_d;
  logic                    resp_err_q, resp_err_d;
  logic                    resp_mis_q, resp_mis_d;
  logic                    req_mis_s;
  logic                    cross_s;
  logic [OFF_W-1:0]        req_size_mask_s;
  logic [ADDR_WIDTH-1:0]   beat_addr_s;
  logic [2*STRB_WIDTH-1:0] wstrb_s;
  logic [2*DATA_WIDTH-1:0] wdata_sh_s;
  logic [DATA_WIDTH-1:0]   rdata_s;

  assign req_ready       = (state_q == ST_IDLE);
  assign resp_valid      = resp_valid_q;
  assign resp_rdata      = resp_rdata_q;
  assign resp_err        = resp_err_q;
  assign resp_misaligned = resp_mis_q;

  assign req_size_mask_s = OFF_W'((4'd1 << req_funct3[1:0]) - 4'd1);
  assign req_mis_s       = |(req_addr[OFF_W-1:0] & req_size_mask_s);
  assign cross_s = ({3'b000, addr_q[OFF_W-1:0]} + (OFF_W + 3)'(4'd1 << f3_q[1:0]))
                   > (OFF_W + 3)'(STRB_WIDTH);
  assign beat_addr_s = addr_q & BEAT_MASK;

`ifdef Z_CORE_LSU_MISALIGN_SPLIT_EN
  logic [DATA_WIDTH-1:0] beat1_q, beat1_d;

  // Second-beat capture; only loads in WAIT2 update it.
  always_comb begin
    beat1_d = (state_q == ST_WAIT2 && mem_ready && !wen_q) ? mem_rdata : beat1_q;
  end

  // Second beat register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      beat1_q <= '0;
    end else begin
      beat1_q <= beat1_d;
    end
  end

  assign beat1_s = beat1_d;
`else
  assign beat1_s = '0;
`endif

  z_core_lsu_align #(
    .DATA_WIDTH (DATA_WIDTH),
    .STRB_WIDTH (STRB_WIDTH),
    .OFF_W      (OFF_W)
  ) u_align (
    .off       (addr_q[OFF_W-1:0]),
    .size_log2 (f3_q[1:0]),
    .zero_ext  (f3_q[2]),
    .wdata     (wdata_q),
    .beat0     (beat0_d),
    .beat1     (beat1_s),
    .wstrb     (wstrb_s),
    .wdata_sh  (wdata_sh_s),
    .rdata     (rdata_s)
  );

  // Sequencer: accept, walk one or two bus beats, then respond.
  always_comb begin
    state_d    = state_q;
    wen_d      = wen_q;
    f3_d       = f3_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    beat0_d    = beat0_q;
    resp_err_d = 1'b0;
    resp_mis_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          wen_d   = req_wen;
          f3_d    = req_funct3;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (lsu_f3_illegal(req_funct3, req_wen, IS_64)) begin
            state_d    = ST_RESP;
            resp_err_d = 1'b1;
          end else if (req_mis_s && !SPLIT_EN) begin
            state_d    = ST_RESP;
            resp_mis_d = 1'b1;
          end else begin
            state_d = ST_ISSUE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: state_d = mem_busy ? ST_ISSUE : ST_WAIT;
      ST_WAIT: begin
        if (mem_ready) begin
          beat0_d = wen_q ? beat0_q : mem_rdata;
          state_d = (SPLIT_EN && cross_s) ? ST_ISSUE2 : ST_RESP;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_ISSUE2: state_d = mem_busy ? ST_ISSUE2 : ST_WAIT2;
      ST_WAIT2:  state_d = mem_ready ? ST_RESP : ST_WAIT2;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    // Rejections leave IDLE straight for RESP and so never carry load data.
    resp_valid_d = (state_d == ST_RESP);
    resp_rdata_d = (state_d == ST_RESP && state_q != ST_IDLE && !wen_q) ? rdata_s : '0;
  end

  // Bus-side drive, active only in the issue states.
  always_comb begin
    mem_req   = 1'b0;
    mem_wen   = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    case (state_q)
      ST_ISSUE: begin
        mem_req   = ~mem_busy;
        mem_wen   = wen_q;
        mem_addr  = beat_addr_s;
        mem_wdata = wdata_sh_s[DATA_WIDTH-1:0];
        mem_wstrb = wen_q ? wstrb_s[STRB_WIDTH-1:0] : '0;
      end
      ST_ISSUE2: begin
        mem_req   = ~mem_busy;
        mem_wen   = wen_q;
        mem_addr  = beat_addr_s + BEAT_BYTES;
        mem_wdata = wdata_sh_s[2*DATA_WIDTH-1:DATA_WIDTH];
        mem_wstrb = wen_q ? wstrb_s[2*STRB_WIDTH-1:STRB_WIDTH] : '0;
      end
      default: begin
        mem_req = 1'b0;
      end
    endcase
  end

  // State, request latch and registered response.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      wen_q        <= 1'b0;
      f3_q         <= 3'b000;
      addr_q       <= '0;
      wdata_q      <= '0;
      beat0_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      resp_mis_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wen_q        <= wen_d;
      f3_q         <= f3_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      beat0_q      <= beat0_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      resp_mis_q   <= resp_mis_d;
    end
  end

endmodule

// File: tb/tb_z_core_lsu.sv
// Scoreboard bench for z_core_lsu at DATA_WIDTH = 32; honours
// Z_CORE_LSU_MISALIGN_SPLIT_EN when the design is built with it.
module tb_z_core_lsu;

  typedef struct {
    logic [31:0] addr;
    logic        wen;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        first;
  } mem_exp_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        mis;
    logic        rejected;
  } resp_exp_t;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req_valid, req_ready, req_wen;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err, resp_misaligned;
  logic [31:0] resp_rdata;
  logic        mem_req, mem_wen, mem_ready, mem_busy;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int accept_cyc = 0;
  int ready_cyc = 0;
  int busy_hold = 0;
  int ready_cnt = 0;
  int mem_lat = 2;
  logic hang_ready = 1'b0;
  logic [31:0] pend_rdata = 32'h0;
  mem_exp_t  mem_q[$];
  resp_exp_t resp_q[$];

  z_core_lsu #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .STRB_WIDTH(4)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .resp_misaligned(resp_misaligned),
    .mem_req(mem_req), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .mem_busy(mem_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push_mem(input logic [31:0] addr, input logic wen, input logic [3:0] strb,
                          input logic [31:0] wdata, input logic [31:0] rdata, input logic first);
    mem_exp_t e;
    e.addr = addr; e.wen = wen; e.strb = strb; e.wdata = wdata; e.rdata = rdata; e.first = first;
    mem_q.push_back(e);
  endtask

  task automatic push_resp(input logic [31:0] rdata, input logic err, input logic mis,
                           input logic rejected);
    resp_exp_t e;
    e.rdata = rdata; e.err = err; e.mis = mis; e.rejected = rejected;
    resp_q.push_back(e);
  endtask

  task automatic drive_req(input logic wen, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata);
    int n;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    req_valid  = 1'b1;
    req_wen    = wen;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    accept_cyc = cyc;
    @(negedge clk);
    req_valid = 1'b0;
    chk("ready_low_c1", req_ready, 1'b0);
  endtask

  task automatic run_req(input logic wen, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata);
    int n;
    drive_req(wen, f3, addr, wdata);
    n = 0;
    while (resp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (resp_q.size() != 0) begin
      chk("resp_timeout", 1'b0, 1'b1);
      resp_q.delete();
    end
    chk("mem_left", mem_q.size(), 0);
    mem_q.delete();
    @(negedge clk);
  endtask

  // Memory side: checks each mem_req against the scoreboard and answers it.
  initial begin : responder
    mem_exp_t me;
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      mem_ready = 1'b0;
      if (!rstn) begin
        ready_cnt = 0;
      end else begin
        if (ready_cnt > 0) begin
          ready_cnt--;
          if (ready_cnt == 0) begin
            mem_ready = 1'b1;
            mem_rdata = pend_rdata;
            ready_cyc = cyc;
          end
        end
        if (mem_req) begin
          if (mem_q.size() == 0) begin
            chk("mem_unexpected", 1'b1, 1'b0);
          end else begin
            me = mem_q.pop_front();
            chk("mem_addr", mem_addr, me.addr);
            chk("mem_wen", mem_wen, me.wen);
            if (me.wen) begin
              chk("mem_wstrb", mem_wstrb, me.strb);
              chk("mem_wdata", mem_wdata, me.wdata);
            end
            if (me.first) chk("mem_req_lat", cyc - accept_cyc, 1 + busy_hold);
            else          chk("mem_req2_lat", cyc - ready_cyc, 1);
            pend_rdata = me.rdata;
            ready_cnt  = hang_ready ? 0 : mem_lat;
          end
        end
      end
    end
  end

  // Response side: compares each resp_valid pulse with the scoreboard.
  initial begin : resp_mon
    resp_exp_t re;
    forever begin
      @(negedge clk);
      if (rstn && resp_valid) begin
        if (resp_q.size() == 0) begin
          chk("resp_unexpected", 1'b1, 1'b0);
        end else begin
          re = resp_q.pop_front();
          chk("resp_rdata", resp_rdata, re.rdata);
          chk("resp_err", resp_err, re.err);
          chk("resp_mis", resp_misaligned, re.mis);
          chk("ready_in_resp", req_ready, 1'b0);
          if (re.rejected) chk("rej_lat", cyc - accept_cyc, 1);
          else             chk("resp_lat", cyc - ready_cyc, 1);
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    rstn = 1'b0; req_valid = 1'b0; req_wen = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0; mem_busy = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_resp_err", resp_err, 1'b0);
    chk("rst_resp_mis", resp_misaligned, 1'b0);
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_wstrb", mem_wstrb, 4'h0);
    rstn = 1'b1;
    @(negedge clk);

    push_mem(32'h100, 1'b1, 4'b1111, 32'hDEADBEEF, 32'h0, 1'b1);
    push_resp(32'h0, 1'b0, 1'b0, 1'b0);
    run_req(1'b1, 3'b010, 32'h100, 32'hDEADBEEF);

    push_mem(32'h100, 1'b1, 4'b1000, 32'hA5000000, 32'h0, 1'b1);
    push_resp(32'h0, 1'b0, 1'b0, 1'b0);
    run_req(1'b1, 3'b000, 32'h103, 32'h000000A5);

    push_mem(32'h100, 1'b0, 4'b0000, 32'h0, 32'h80706050, 1'b1);
    push_resp(32'hFFFFFF80, 1'b0, 1'b0, 1'b0);
    run_req(1'b0, 3'b000, 32'h103, 32'h0);

    push_mem(32'h100, 1'b0, 4'b0000, 32'h0, 32'h80706050, 1'b1);
    push_resp(32'h00000080, 1'b0, 1'b0, 1'b0);
    run_req(1'b0, 3'b100, 32'h103, 32'h0);

    push_mem(32'h100, 1'b0, 4'b0000, 32'h0, 32'h9ABC1234, 1'b1);
    push_resp(32'hFFFF9ABC, 1'b0, 1'b0, 1'b0);
    run_req(1'b0, 3'b001, 32'h102, 32'h0);

    push_mem(32'h100, 1'b0, 4'b0000, 32'h0, 32'h9ABC1234, 1'b1);
    push_resp(32'h00009ABC, 1'b0, 1'b0, 1'b0);
    run_req(1'b0, 3'b101, 32'h102, 32'h0);

    push_mem(32'h200, 1'b1, 4'b1100, 32'hBEEF0000, 32'h0, 1'b1);
    push_resp(32'h0, 1'b0, 1'b0, 1'b0);
    run_req(1'b1, 3'b001, 32'h202, 32'h1234BEEF);

    // LW with the master busy for two cycles after accept.
    mem_busy  = 1'b1;
    busy_hold = 2;
    push_mem(32'h104, 1'b0, 4'b0000, 32'h0, 32'h12345678, 1'b1);
    push_resp(32'h12345678, 1'b0, 1'b0, 1'b0);
    fork
      begin
        repeat (busy_hold + 1) @(posedge clk);
        #1 mem_busy = 1'b0;
      end
      run_req(1'b0, 3'b010, 32'h104, 32'h0);
    join
    busy_hold = 0;

`ifdef Z_CORE_LSU_MISALIGN_SPLIT_EN
    push_mem(32'h100, 1'b0, 4'b0000, 32'h0, 32'h80706050, 1'b1);
    push_mem(32'h104, 1'b0, 4'b0000, 32'h0, 32'h11223344, 1'b0);
    push_resp(32'h00004480, 1'b0, 1'b0, 1'b0);
    run_req(1'b0, 3'b001, 32'h103, 32'h0);

    push_mem(32'h100, 1'b1, 4'b1100, 32'hCCDD0000, 32'h0, 1'b1);
    push_mem(32'h104, 1'b1, 4'b0011, 32'h0000AABB, 32'h0, 1'b0);
    push_resp(32'h0, 1'b0, 1'b0, 1'b0);
    run_req(1'b1, 3'b010, 32'h102, 32'hAABBCCDD);
`else
    push_resp(32'h0, 1'b0, 1'b1, 1'b1);
    run_req(1'b0, 3'b001, 32'h103, 32'h0);

    push_resp(32'h0, 1'b0, 1'b1, 1'b1);
    run_req(1'b1, 3'b010, 32'h102, 32'hAABBCCDD);
`endif

    // Illegal funct3: LD and LWU at width 32, BU store, 111 load.
    push_resp(32'h0, 1'b1, 1'b0, 1'b1);
    run_req(1'b0, 3'b011, 32'h100, 32'h0);
    push_resp(32'h0, 1'b1, 1'b0, 1'b1);
    run_req(1'b0, 3'b110, 32'h100, 32'h0);
    push_resp(32'h0, 1'b1, 1'b0, 1'b1);
    run_req(1'b1, 3'b100, 32'h100, 32'h55);
    push_resp(32'h0, 1'b1, 1'b0, 1'b1);
    run_req(1'b0, 3'b111, 32'h100, 32'h0);

    // Reset while waiting on the bus: no response, idle afterwards.
    hang_ready = 1'b1;
    push_mem(32'h300, 1'b0, 4'b0000, 32'h0, 32'hCAFEF00D, 1'b1);
    drive_req(1'b0, 3'b010, 32'h300, 32'h0);
    repeat (3) @(negedge clk);
    chk("wait_mem_issued", mem_q.size(), 0);
    chk("wait_no_req", mem_req, 1'b0);
    rstn = 1'b0;
    #1;
    chk("rst_wait_ready", req_ready, 1'b1);
    chk("rst_wait_mem_req", mem_req, 1'b0);
    chk("rst_wait_resp", resp_valid, 1'b0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    hang_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("post_rst_no_resp", resp_valid, 1'b0);
    end
    chk("post_rst_ready", req_ready, 1'b1);

    push_mem(32'h100, 1'b0, 4'b0000, 32'h0, 32'h0000807F, 1'b1);
    push_resp(32'h0000007F, 1'b0, 1'b0, 1'b0);
    run_req(1'b0, 3'b000, 32'h100, 32'h0);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
